// File: rtl/dsp_pkg.sv
// dsp_pkg: OPMODE encodings, the pipeline tag record and its width, shared by the MAC sequencer files
package dsp_pkg;
  localparam logic [7:0] OPMODE_LOAD = 8'h01;
  localparam logic [7:0] OPMODE_ACC  = 8'h09;
  localparam logic [7:0] OPMODE_HOLD = 8'h08;
  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;
  localparam int TAG_W = $bits(tag_t);
endpackage

// File: rtl/dsp_tag_pipe.sv
// dsp_tag_pipe: DEPTH-stage tag delay line (CLK, RSTN async low, ce advance, clr zero all, d in, mid = stage MID, last = stage DEPTH)
module dsp_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 3,
  parameter int MID   = 2
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         ce,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] mid,
  output logic [W-1:0] last
);
  logic [W-1:0] stg [DEPTH];
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) stg <= '{default: '0};
    else if (clr) stg <= '{default: '0};
    else if (ce) begin
      stg[0] <= d;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  assign mid  = stg[MID-1];
  assign last = stg[DEPTH-1];
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: drives a DSP48A1-style slice for TAPS-term dot products (s_* operand stream in, m_* results out, dsp_* slice side)
module dsp_mac_sequencer
  import dsp_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int PIPE_LAT = 3,
  parameter int OP_DLY   = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        clr,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [17:0] s_a,
  input  logic [17:0] s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [47:0] m_data,
  output logic        m_carry,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  output logic        dsp_ce,
  input  logic [47:0] dsp_p,
  input  logic        dsp_carryout
);
  localparam int CW = TAPS > 1 ? $clog2(TAPS) : 1;
  logic [CW-1:0] tap_cnt;
  logic [TAG_W-1:0] op_raw, out_raw;
  tag_t op_tag, out_tag;
  logic acc, cap, tap_last;
  assign s_ready = !(m_valid && !m_ready);
  assign dsp_ce = s_ready;
  assign acc = s_valid && s_ready && !clr;
  assign tap_last = tap_cnt == CW'(TAPS - 1);
  assign dsp_a = acc ? s_a : '0;
  assign dsp_b = acc ? s_b : '0;
  dsp_tag_pipe #(.DEPTH(PIPE_LAT), .W(TAG_W), .MID(OP_DLY)) u_pipe (
    .CLK  (CLK),
    .RSTN (RSTN),
    .ce   (dsp_ce),
    .clr  (clr),
    .d    ({acc, tap_cnt == '0, tap_last}),
    .mid  (op_raw),
    .last (out_raw)
  );
  assign op_tag = tag_t'(op_raw);
  assign out_tag = tag_t'(out_raw);
  assign dsp_opmode = !op_tag.v ? OPMODE_HOLD : op_tag.first ? OPMODE_LOAD : OPMODE_ACC;
  assign cap = dsp_ce && out_tag.v && out_tag.last;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) tap_cnt <= '0;
    else if (clr) tap_cnt <= '0;
    else if (acc) tap_cnt <= tap_last ? '0 : tap_cnt + CW'(1);
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_carry <= 1'b0;
    end else begin
      if (cap) begin
        m_data  <= dsp_p;
        m_carry <= dsp_carryout;
      end
      m_valid <= cap || (m_valid && !m_ready);
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: table-driven cycle checks plus clr/reset sequences against a cycle-accurate slice model
module tb_dsp_mac_sequencer;
  logic CLK = 0, RSTN = 0, clr = 0, s_valid = 0, m_ready = 1;
  logic [17:0] s_a = 0, s_b = 0;
  logic s_ready, m_valid, m_carry, dsp_ce, dsp_carryout;
  logic [17:0] dsp_a, dsp_b;
  logic [47:0] m_data, dsp_p;
  logic [7:0] dsp_opmode;
  always #5 CLK = ~CLK;
  dsp_mac_sequencer #(.TAPS(4), .PIPE_LAT(3), .OP_DLY(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .clr(clr), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_carry(m_carry), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
  );
  logic [17:0] a1 = 0, b1 = 0;
  logic [35:0] mreg = 0;
  logic [47:0] p = 0;
  logic c = 0;
  always @(posedge CLK)
    if (dsp_ce) begin
      a1 <= dsp_a;
      b1 <= dsp_b;
      mreg <= a1 * b1;
      case (dsp_opmode)
        8'h01: {c, p} <= {13'b0, mreg};
        8'h09: {c, p} <= {1'b0, p} + {13'b0, mreg};
        default: begin end
      endcase
    end
  assign dsp_p = p;
  assign dsp_carryout = c;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  typedef struct {
    logic sv;
    logic [17:0] a, b;
    logic mr, sr, mv;
    logic [47:0] md;
    logic [7:0] op;
  } vec_t;
  vec_t vt[$];
  task automatic add(input logic sv, input logic [17:0] a, input logic [17:0] b, input logic mr,
                     input logic sr, input logic mv, input logic [47:0] md, input logic [7:0] op);
    vt.push_back('{sv, a, b, mr, sr, mv, md, op});
  endtask
  task automatic cyc(input logic sv, input logic [17:0] a, input logic [17:0] b, input logic mr, input logic cl);
    @(negedge CLK);
    s_valid = sv; s_a = a; s_b = b; m_ready = mr; clr = cl;
    #1;
  endtask
  localparam logic [47:0] BIG = 48'd4 * 48'h3FFFF * 48'h3FFFF;
  int n;
  initial begin
    add(1, 1, 2, 1, 1, 0, 0, 8'h08); add(1, 2, 2, 1, 1, 0, 0, 8'h08);
    add(1, 3, 2, 1, 1, 0, 0, 8'h01); add(1, 4, 2, 1, 1, 0, 0, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08); add(0, 0, 0, 1, 1, 1, 20, 8'h08);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 1, 2, 1, 1, 0, 0, 8'h08); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 2, 2, 1, 1, 0, 0, 8'h01); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 3, 2, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 4, 2, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(0, 0, 0, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(0, 0, 0, 1, 1, 1, 20, 8'h08); add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 1, 1, 0, 1, 0, 0, 8'h08); add(1, 1, 1, 0, 1, 0, 0, 8'h08);
    add(1, 1, 1, 0, 1, 0, 0, 8'h01); add(1, 1, 1, 0, 1, 0, 0, 8'h09);
    add(1, 1, 1, 0, 1, 0, 0, 8'h09); add(1, 1, 1, 0, 1, 0, 0, 8'h09);
    add(1, 1, 1, 0, 1, 0, 0, 8'h01); add(1, 1, 1, 0, 0, 1, 4, 8'h09);
    add(1, 1, 1, 0, 0, 1, 4, 8'h09); add(1, 1, 1, 1, 1, 1, 4, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08); add(0, 0, 0, 1, 1, 1, 4, 8'h08);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    add(1, 18'h3FFFF, 18'h3FFFF, 1, 1, 0, 0, 8'h08); add(1, 18'h3FFFF, 18'h3FFFF, 1, 1, 0, 0, 8'h08);
    add(1, 18'h3FFFF, 18'h3FFFF, 1, 1, 0, 0, 8'h01); add(1, 18'h3FFFF, 18'h3FFFF, 1, 1, 0, 0, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h09); add(0, 0, 0, 1, 1, 0, 0, 8'h09);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08); add(0, 0, 0, 1, 1, 1, BIG, 8'h08);
    add(0, 0, 0, 1, 1, 0, 0, 8'h08);
    repeat (2) @(negedge CLK);
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst m_data", m_data, 0);
    chk("rst m_carry", m_carry, 0);
    chk("rst s_ready", s_ready, 1);
    chk("rst dsp_ce", dsp_ce, 1);
    chk("rst opmode", dsp_opmode, 8'h08);
    #2 RSTN = 1;
    foreach (vt[i]) begin
      cyc(vt[i].sv, vt[i].a, vt[i].b, vt[i].mr, 0);
      chk($sformatf("v%0d s_ready", i), s_ready, vt[i].sr);
      chk($sformatf("v%0d dsp_ce", i), dsp_ce, vt[i].sr);
      chk($sformatf("v%0d m_valid", i), m_valid, vt[i].mv);
      chk($sformatf("v%0d opmode", i), dsp_opmode, vt[i].op);
      chk($sformatf("v%0d dsp_a", i), dsp_a, (vt[i].sv && vt[i].sr) ? vt[i].a : 18'd0);
      if (vt[i].mv) begin
        chk($sformatf("v%0d m_data", i), m_data, vt[i].md);
        chk($sformatf("v%0d m_carry", i), m_carry, 0);
      end
    end
    cyc(1, 5, 5, 1, 0);
    cyc(1, 5, 5, 1, 0);
    cyc(1, 9, 9, 1, 1);
    chk("clr s_ready", s_ready, 1);
    chk("clr dsp_a", dsp_a, 0);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(k < 4, 3, 3, 1, 0);
      if (m_valid) begin
        n++;
        chk("clr m_data", m_data, 36);
      end
    end
    chk("clr result count", n, 1);
    for (int k = 0; k < 6; k++) cyc(1, 2, 2, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("pre-rst m_valid", m_valid, 1);
    chk("pre-rst m_data", m_data, 16);
    chk("pre-rst s_ready", s_ready, 0);
    #2 RSTN = 0;
    #1;
    chk("async rst m_valid", m_valid, 0);
    chk("async rst m_data", m_data, 0);
    chk("async rst s_ready", s_ready, 1);
    chk("async rst opmode", dsp_opmode, 8'h08);
    @(negedge CLK);
    #2 RSTN = 1;
    n = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(k < 4, 1, 1, 1, 0);
      if (m_valid) begin
        n++;
        chk("post-rst m_data", m_data, 4);
      end
    end
    chk("post-rst result count", n, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
